// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths, divider state encoding and
// the common enable/disable encodings.
package cpu_defs_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_BUS_W = DATA_W;
  localparam int unsigned WORK_W    = 2 * DATA_W;
  localparam int unsigned CNT_W     = $clog2(DATA_W);

  typedef logic [REG_BUS_W-1:0] reg_bus_t;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam reg_bus_t DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  localparam logic [CNT_W-1:0] DIV_CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring division iteration on the {remainder, quotient} working
// register: shift, trial-subtract the divisor, shift in the quotient bit.
module mdu_div_step
  import cpu_defs_pkg::*;
(
  input  logic [WORK_W-1:0] work_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [WORK_W-1:0] work_o
);

  // Upper 33 bits after the shift; the extra bit keeps the trial exact.
  logic [DATA_W:0] trial;

  always_comb begin
    trial  = work_i[WORK_W-1:DATA_W-1] - {1'b0, divisor_i};
    work_o = {work_i[WORK_W-2:0], 1'b0};
    if (!trial[DATA_W]) begin
      work_o = {trial[DATA_W-1:0], work_i[DATA_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mdu_div.sv
// Multi-cycle 32-bit DIV/DIVU unit: remainder to HI, quotient to LO,
// ready_o doubles as the HI/LO write enable.
module mdu_div
  import cpu_defs_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              annul_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] opdata1_i,
  input  logic [DATA_W-1:0] opdata2_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              ready_o,
  output logic              busy_o
);

  div_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORK_W-1:0] work_q;
  logic [WORK_W-1:0] work_d;
  reg_bus_t          divisor_q;
  logic              neg_quot_q;
  logic              neg_rem_q;
  reg_bus_t          hi_q;
  reg_bus_t          lo_q;
  logic              ready_q;

  reg_bus_t          abs_dividend;
  reg_bus_t          abs_divisor;
  reg_bus_t          quot_raw;
  reg_bus_t          rem_raw;
  logic              div_by_zero;

  mdu_div_step u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_d)
  );

  // Magnitudes as unsigned values, so |0x80000000| stays 0x80000000.
  always_comb begin
    abs_dividend = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    abs_divisor  = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
    div_by_zero  = (opdata2_i == '0);
    quot_raw     = work_d[DATA_W-1:0];
    rem_raw      = work_d[WORK_W-1:DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      ready_q    <= DISABLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (annul_i == ENABLE) begin
            state_q <= DIV_IDLE;
          end else if (start_i == ENABLE) begin
            if (div_by_zero) begin
              hi_q    <= opdata1_i;
              lo_q    <= DIV_ZERO_QUOT;
              ready_q <= ENABLE;
              state_q <= DIV_DONE;
            end else begin
              work_q     <= {{DATA_W{1'b0}}, abs_dividend};
              divisor_q  <= abs_divisor;
              neg_quot_q <= signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
              neg_rem_q  <= signed_i & opdata1_i[DATA_W-1];
              cnt_q      <= '0;
              state_q    <= DIV_BUSY;
            end
          end
        end

        DIV_BUSY: begin
          if (annul_i == ENABLE) begin
            state_q <= DIV_IDLE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            // Last iteration: apply sign fix-up straight from the step output.
            if (cnt_q == DIV_CNT_LAST) begin
              lo_q    <= neg_quot_q ? -quot_raw : quot_raw;
              hi_q    <= neg_rem_q ? -rem_raw : rem_raw;
              ready_q <= ENABLE;
              state_q <= DIV_DONE;
            end
          end
        end

        DIV_DONE: begin
          if ((start_i == DISABLE) || (annul_i == ENABLE)) begin
            ready_q <= DISABLE;
            state_q <= DIV_IDLE;
          end
        end

        default: begin
          ready_q <= DISABLE;
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  // Stall must rise in the start cycle itself, hence combinational.
  assign busy_o  = (state_q == DIV_BUSY) ||
                   ((state_q == DIV_IDLE) && start_i && !annul_i && !div_by_zero);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign ready_o = ready_q;

endmodule

// File: tb/tb_mdu_div.sv
// Self-checking bench for mdu_div: directed corner cases plus random
// divides compared against a magnitude/sign arithmetic reference.
module tb_mdu_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        ready_o;
  logic        busy_o;

  int n_pass  = 0;
  int n_total = 0;

  mdu_div dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .ready_o   (ready_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Truncating division from magnitudes and signs; fixed result for /0.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r);
    logic [31:0] ua, ub;
    logic nq, nr;
    if (b == 0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      nr = s && a[31];
      nq = s && (a[31] ^ b[31]);
      ua = nr ? -a : a;
      ub = (s && b[31]) ? -b : b;
      q  = ua / ub;
      r  = ua % ub;
      if (nq) q = -q;
      if (nr) r = -r;
    end
  endtask

  task automatic wait_result(input logic [31:0] a, input logic [31:0] b, input logic s,
                             input string tag);
    int cyc = 0;
    int nbusy = 0;
    bit got = 0;
    logic [31:0] q, r;
    ref_div(a, b, s, q, r);
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (ready_o) got = 1;
      else begin
        if (busy_o) nbusy++;
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = 1'($urandom);
      end
    end
    check({tag, "/latency"}, 32'(cyc), (b == 0) ? 32'd1 : 32'd33);
    check({tag, "/busy_cycles"}, 32'(nbusy), (b == 0) ? 32'd0 : 32'd32);
    check({tag, "/lo"}, lo_o, q);
    check({tag, "/hi"}, hi_o, r);
    @(posedge clk); #1;
    check({tag, "/ready_hold"}, 32'(ready_o), 32'd1);
    check({tag, "/lo_hold"}, lo_o, q);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "/ready_drop"}, 32'(ready_o), 32'd0);
    check({tag, "/busy_idle"}, 32'(busy_o), 32'd0);
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input string tag);
    @(negedge clk);
    start_i   = 1'b1;
    signed_i  = s;
    opdata1_i = a;
    opdata2_i = b;
    #1;
    check({tag, "/busy_start"}, 32'(busy_o), (b != 0) ? 32'd1 : 32'd0);
    wait_result(a, b, s, tag);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, prev_hi, prev_lo;
    logic s;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset/hi", hi_o, 32'd0);
    check("reset/lo", lo_o, 32'd0);
    check("reset/ready", 32'(ready_o), 32'd0);
    check("reset/busy", 32'(busy_o), 32'd0);
    rst = 1'b0;

    run_div(32'd100, 32'd7, 1'b0, "u100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, "s_m7_2");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, "u_m7_2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "s_min_m1");
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "u_max_max");
    run_div(32'h1234_5678, 32'd0, 1'b1, "s_div0");
    run_div(32'h1234_5678, 32'd0, 1'b0, "u_div0");
    run_div(32'd0, 32'hFFFF_FFF9, 1'b1, "s_zero_num");

    // Annul mid-divide: no ready, previous result retained.
    prev_hi = hi_o;
    prev_lo = lo_o;
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd7;
    repeat (10) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul/ready", 32'(ready_o), 32'd0);
    check("annul/busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("annul/ready_later", 32'(ready_o), 32'd0);
    check("annul/hi_kept", hi_o, prev_hi);
    check("annul/lo_kept", lo_o, prev_lo);
    run_div(32'd9, 32'd3, 1'b0, "post_annul_9_3");

    // Asynchronous reset between edges while busy, start left asserted.
    run_div(32'd100, 32'd7, 1'b0, "pre_rst");
    @(negedge clk);
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd5000; opdata2_i = 32'd13;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst/hi", hi_o, 32'd0);
    check("arst/lo", lo_o, 32'd0);
    check("arst/ready", 32'(ready_o), 32'd0);
    check("arst/busy_idle_start", 32'(busy_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_result(32'd5000, 32'd13, 1'b0, "arst_restart");

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2, 3: b = 32'($urandom_range(1, 15)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
        default: b = $urandom;
      endcase
      s = 1'($urandom);
      run_div(a, b, s, $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
